assoc_score_accum: RTL and testbench

Parametrised multi-class score accumulator for the sequential associative-memory search. Each beat, it takes one partial similarity sum per class, one segment of the query hypervector, and accumulates these over NUM_SEGMENTS beats. After the last segment it runs a sequential argmax over the class scores and reports the winning class and its score. It sits between the per-segment popcount/compare stage and the classifier output register.

---
 rtl/assoc_score_accum.sv | 92 +++++++++
 tb/tb_assoc_score_accum.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/assoc_score_accum.sv
// assoc_score_accum: accumulates per-class partial sums over NUM_SEGMENTS beats, then runs a sequential argmax.
// Define ASSOC_SCORE_SAT_EN to make accumulators saturate at all-ones instead of wrapping.
module assoc_score_accum #(
    parameter int NUM_CLASSES  = 4,
    parameter int NUM_SEGMENTS = 4,
    parameter int SUM_W        = 3,
    parameter int SCORE_W      = 7,
    parameter int IDX_W        = $clog2(NUM_CLASSES)
) (
    input  logic                             clk,
    input  logic                             nrst,
    input  logic                             start,
    input  logic                             in_valid,
    input  logic [NUM_CLASSES*SUM_W-1:0]     sum_in,
    output logic                             busy,
    output logic [NUM_CLASSES*SCORE_W-1:0]   scores,
    output logic                             done,
    output logic [IDX_W-1:0]                 winner,
    output logic [SCORE_W-1:0]               winner_score
);
    typedef enum logic [1:0] {IDLE, ACCUM, SEARCH, DONE} state_t;
    localparam int SEG_W = NUM_SEGMENTS > 1 ? $clog2(NUM_SEGMENTS) : 1;
    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(NUM_SEGMENTS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CLASSES - 1);
    state_t                           state_q;
    logic [SEG_W-1:0]                 seg_q;
    logic [IDX_W-1:0]                 idx_q, best_idx_q, cand_idx;
    logic [SCORE_W-1:0]               best_q, cur, cand;
    logic [NUM_CLASSES*SCORE_W-1:0]   scores_q, scores_d;
    logic                             take;
    // In IDLE the first beat loads rather than adds, so stale scores never leak in.
    for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_acc
        logic [SCORE_W-1:0] base, ext;
        assign base = (state_q == IDLE) ? '0 : scores_q[g*SCORE_W +: SCORE_W];
        assign ext  = SCORE_W'(sum_in[g*SUM_W +: SUM_W]);
`ifdef ASSOC_SCORE_SAT_EN
        logic [SCORE_W:0] wide;
        assign wide = {1'b0, base} + {1'b0, ext};
        assign scores_d[g*SCORE_W +: SCORE_W] = wide[SCORE_W] ? '1 : wide[SCORE_W-1:0];
`else
        assign scores_d[g*SCORE_W +: SCORE_W] = base + ext;
`endif
    end
    // Strict compare keeps the lowest index on ties.
    assign cur      = scores_q[idx_q*SCORE_W +: SCORE_W];
    assign take     = (idx_q == '0) || (cur > best_q);
    assign cand     = take ? cur : best_q;
    assign cand_idx = take ? idx_q : best_idx_q;
    assign busy     = state_q != IDLE;
    assign scores   = scores_q;
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            seg_q        <= '0;
            idx_q        <= '0;
            best_q       <= '0;
            best_idx_q   <= '0;
            scores_q     <= '0;
            done         <= 1'b0;
            winner       <= '0;
            winner_score <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    scores_q <= in_valid ? scores_d : '0;
                    seg_q    <= (in_valid && NUM_SEGMENTS > 1) ? SEG_W'(1) : '0;
                    state_q  <= (in_valid && NUM_SEGMENTS == 1) ? SEARCH : ACCUM;
                end
                ACCUM: if (in_valid) begin
                    scores_q <= scores_d;
                    seg_q    <= (seg_q == SEG_LAST) ? '0 : seg_q + 1'b1;
                    state_q  <= (seg_q == SEG_LAST) ? SEARCH : ACCUM;
                end
                SEARCH: begin
                    best_q     <= cand;
                    best_idx_q <= cand_idx;
                    idx_q      <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        winner       <= cand_idx;
                        winner_score <= cand;
                        done         <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_assoc_score_accum.sv
// tb_assoc_score_accum: directed vector table plus hand sequences for reset and back-to-back queries.
module tb_assoc_score_accum;
    logic        clk = 1'b0;
    logic        nrst, start, in_valid;
    logic [11:0] sum_in;
    logic        busy, done, busy4, done4;
    logic [27:0] scores;
    logic [15:0] scores4;
    logic [1:0]  winner, winner4;
    logic [6:0]  winner_score;
    logic [3:0]  winner_score4;
    int          n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    assoc_score_accum dut (
        .clk(clk), .nrst(nrst), .start(start), .in_valid(in_valid), .sum_in(sum_in),
        .busy(busy), .scores(scores), .done(done), .winner(winner), .winner_score(winner_score)
    );

    assoc_score_accum #(.SCORE_W(4)) dut4 (
        .clk(clk), .nrst(nrst), .start(start), .in_valid(in_valid), .sum_in(sum_in),
        .busy(busy4), .scores(scores4), .done(done4), .winner(winner4), .winner_score(winner_score4)
    );

    typedef struct {
        logic [3:0][11:0] beats;
        bit               merged;
        bit               gaps;
        logic [27:0]      exp_scores;
        logic [1:0]       exp_win;
        logic [6:0]       exp_ws;
        bit               chk4;
        logic [3:0]       exp4;
    } vec_t;

    vec_t vt[6];

    function automatic logic [11:0] pk3(input int a, input int b, input int c, input int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    function automatic logic [27:0] pk7(input int a, input int b, input int c, input int d);
        return {7'(d), 7'(c), 7'(b), 7'(a)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Enters and leaves just after a falling edge with the DUT idle.
    task automatic run_query(input vec_t v, input int id);
        int cnt;
        start    = 1'b1;
        in_valid = v.merged;
        sum_in   = v.beats[0];
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        sum_in   = '1;
        for (int i = (v.merged ? 1 : 0); i < 4; i++) begin
            for (int g = 0; g < (v.gaps ? i : 0); g++) begin
                start = (g == 0);
                @(negedge clk);
            end
            start    = 1'b0;
            in_valid = 1'b1;
            sum_in   = v.beats[i];
            @(negedge clk);
            in_valid = 1'b0;
            sum_in   = '1;
        end
        cnt   = 0;
        start = v.gaps;
        while (done !== 1'b1 && cnt < 12) begin
            @(negedge clk);
            start = 1'b0;
            cnt++;
        end
        chk($sformatf("v%0d latency", id), 64'(cnt), 64'd4);
        chk($sformatf("v%0d scores", id), 64'(scores), 64'(v.exp_scores));
        chk($sformatf("v%0d winner", id), 64'(winner), 64'(v.exp_win));
        chk($sformatf("v%0d winner_score", id), 64'(winner_score), 64'(v.exp_ws));
        if (v.chk4) begin
            chk($sformatf("v%0d w4 winner", id), 64'(winner4), 64'd0);
            chk($sformatf("v%0d w4 winner_score", id), 64'(winner_score4), 64'(v.exp4));
        end
        @(negedge clk);
        chk($sformatf("v%0d done_width", id), 64'(done), 64'd0);
        chk($sformatf("v%0d busy_idle", id), 64'(busy), 64'd0);
    endtask

    initial begin
        logic [3:0] e4;
        bit         seen;
`ifdef ASSOC_SCORE_SAT_EN
        e4 = 4'd15;
`else
        e4 = 4'd12;
`endif
        vt[0] = '{beats: {4{pk3(1,7,3,7)}}, merged: 0, gaps: 0,
                  exp_scores: pk7(4,28,12,28), exp_win: 1, exp_ws: 28, chk4: 0, exp4: 0};
        vt[1] = '{beats: {pk3(0,1,1,0), pk3(0,1,1,0), pk3(0,1,1,0), pk3(2,0,0,5)}, merged: 1, gaps: 0,
                  exp_scores: pk7(2,3,3,5), exp_win: 3, exp_ws: 5, chk4: 0, exp4: 0};
        vt[2] = '{beats: {4{pk3(1,7,3,7)}}, merged: 0, gaps: 1,
                  exp_scores: pk7(4,28,12,28), exp_win: 1, exp_ws: 28, chk4: 0, exp4: 0};
        vt[3] = '{beats: {4{pk3(0,0,0,0)}}, merged: 0, gaps: 0,
                  exp_scores: pk7(0,0,0,0), exp_win: 0, exp_ws: 0, chk4: 0, exp4: 0};
        vt[4] = '{beats: {4{pk3(7,1,1,1)}}, merged: 1, gaps: 1,
                  exp_scores: pk7(28,4,4,4), exp_win: 0, exp_ws: 28, chk4: 1, exp4: e4};
        vt[5] = '{beats: {pk3(0,0,2,0), pk3(0,0,0,1), pk3(0,0,0,1), pk3(0,0,0,1)}, merged: 0, gaps: 0,
                  exp_scores: pk7(0,0,2,3), exp_win: 3, exp_ws: 3, chk4: 0, exp4: 0};

        nrst = 1'b0; start = 1'b0; in_valid = 1'b0; sum_in = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset scores", 64'(scores), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset winner", 64'(winner), 64'd0);
        chk("reset winner_score", 64'(winner_score), 64'd0);
        nrst = 1'b1;
        in_valid = 1'b1; sum_in = pk3(5,5,5,5);
        @(negedge clk);
        in_valid = 1'b0;
        chk("idle in_valid ignored busy", 64'(busy), 64'd0);
        chk("idle in_valid ignored scores", 64'(scores), 64'd0);

        for (int k = 0; k < 6; k++) run_query(vt[k], k);

        // Back-to-back start right after done: scores clear, previous result held.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b scores cleared", 64'(scores), 64'd0);
        chk("b2b busy", 64'(busy), 64'd1);
        chk("b2b winner held", 64'(winner), 64'd3);
        chk("b2b winner_score held", 64'(winner_score), 64'd3);
        in_valid = 1'b1; sum_in = pk3(1,7,3,7);
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        chk("partial scores", 64'(scores), 64'(pk7(2,14,6,14)));
        chk("partial winner held", 64'(winner), 64'd3);

        // Asynchronous reset after beat 2 of 4.
        nrst = 1'b0;
        #1;
        chk("midreset scores", 64'(scores), 64'd0);
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset done", 64'(done), 64'd0);
        chk("midreset winner", 64'(winner), 64'd0);
        chk("midreset winner_score", 64'(winner_score), 64'd0);
        @(negedge clk);
        nrst = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("no done after reset", 64'(seen), 64'd0);
        run_query(vt[0], 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
